// File: rtl/e_mem_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the E_MEM read arbiter.
package e_mem_arbiter_pkg;

  localparam int REG_SIZE = 16;
  localparam int MEM_SIZE = 1024;

  localparam logic [1:0] EMA_ST_ARB   = 2'd0;
  localparam logic [1:0] EMA_ST_LOCK0 = 2'd1;
  localparam logic [1:0] EMA_ST_LOCK1 = 2'd2;

  typedef enum logic [1:0] {
    ST_ARB   = EMA_ST_ARB,
    ST_LOCK0 = EMA_ST_LOCK0,
    ST_LOCK1 = EMA_ST_LOCK1
  } ema_state_t;

  function automatic logic addr_oor(input logic [REG_SIZE-1:0] addr);
    return (addr >= REG_SIZE'(MEM_SIZE));
  endfunction

endpackage

// File: rtl/e_mem_arbiter_rr_pick2.sv
// Two-input round-robin selector: one-hot grant, favouring port rr on contention.
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr,
  output logic [1:0] gnt_oh
);

  always_comb begin
    gnt_oh = 2'b00;
    if (req0 && req1) begin
      gnt_oh = rr ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt_oh = 2'b01;
    end else if (req1) begin
      gnt_oh = 2'b10;
    end else begin
      gnt_oh = 2'b00;
    end
  end

endmodule

// File: rtl/e_mem_arbiter.sv
// Round-robin two-port read arbiter with locked bursts for single-port E_MEM.
// Optional out-of-range read flagging is enabled by defining E_MEM_BOUNDS_CHECK_EN.
module e_mem_arbiter
  import e_mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [REG_SIZE-1:0] addr0,
  input  logic [REG_SIZE-1:0] addr1,
  input  logic                lock0,
  input  logic                lock1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [REG_SIZE-1:0] mem_address,
  input  logic [REG_SIZE-1:0] mem_data,
  output logic [REG_SIZE-1:0] rdata,
  output logic                err
);

  localparam int         BW         = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B   = BW'(MAX_BURST);
  localparam logic       MULTI_BEAT = (MAX_BURST > 1);

  ema_state_t          r_state, w_state_nxt;
  logic                r_rr, w_rr_nxt;
  logic [BW-1:0]       r_beat, w_beat_nxt, w_beat_inc;
  logic [1:0]          w_pick;
  logic                w_gnt0, w_gnt1, w_any;
  logic [REG_SIZE-1:0] w_gnt_addr;
  logic                w_oor;
  logic [REG_SIZE-1:0] r_addr;
  logic                r_tag_valid, r_tag_port;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .rr     (r_rr),
    .gnt_oh (w_pick)
  );

  assign w_beat_inc = r_beat + BW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_beat_nxt  = r_beat;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (rst) begin
      w_state_nxt = ST_ARB;
    end else begin
      case (r_state)
        ST_ARB: begin
          w_gnt0 = w_pick[0];
          w_gnt1 = w_pick[1];
          if (w_pick[0]) begin
            w_rr_nxt = 1'b1;
            if (lock0 && MULTI_BEAT) begin
              w_state_nxt = ST_LOCK0;
              w_beat_nxt  = BW'(1);
            end
          end else if (w_pick[1]) begin
            w_rr_nxt = 1'b0;
            if (lock1 && MULTI_BEAT) begin
              w_state_nxt = ST_LOCK1;
              w_beat_nxt  = BW'(1);
            end
          end
        end
        ST_LOCK0: begin
          w_gnt0 = req0;
          // Dropping the lock ends the burst even if this cycle is still granted.
          if (!lock0 || (req0 && (w_beat_inc == MAX_B))) begin
            w_state_nxt = ST_ARB;
            w_rr_nxt    = 1'b1;
            w_beat_nxt  = {BW{1'b0}};
          end else if (req0) begin
            w_beat_nxt = w_beat_inc;
          end
        end
        ST_LOCK1: begin
          w_gnt1 = req1;
          if (!lock1 || (req1 && (w_beat_inc == MAX_B))) begin
            w_state_nxt = ST_ARB;
            w_rr_nxt    = 1'b0;
            w_beat_nxt  = {BW{1'b0}};
          end else if (req1) begin
            w_beat_nxt = w_beat_inc;
          end
        end
        default: begin
          w_state_nxt = ST_ARB;
          w_beat_nxt  = {BW{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
      r_rr    <= 1'b0;
      r_beat  <= {BW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign w_any      = w_gnt0 | w_gnt1;
  assign w_gnt_addr = w_gnt1 ? addr1 : addr0;

`ifdef E_MEM_BOUNDS_CHECK_EN
  logic r_tag_oor;
  assign w_oor = w_any & addr_oor(w_gnt_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_oor <= 1'b0;
    end else begin
      r_tag_oor <= w_oor;
    end
  end

  assign rdata = r_tag_oor ? {REG_SIZE{1'b0}} : mem_data;
  assign err   = r_tag_valid & r_tag_oor;
`else
  assign w_oor = 1'b0;
  assign rdata = mem_data;
  assign err   = 1'b0;
`endif

  // Out-of-range grants leave the memory address where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= {REG_SIZE{1'b0}};
      r_tag_valid <= 1'b0;
      r_tag_port  <= 1'b0;
    end else begin
      if (w_any && !w_oor) begin
        r_addr <= w_gnt_addr;
      end
      r_tag_valid <= w_any;
      r_tag_port  <= w_gnt1;
    end
  end

  assign mem_address = (w_any && !w_oor) ? w_gnt_addr : r_addr;
  assign gnt0        = w_gnt0;
  assign gnt1        = w_gnt1;
  assign rvalid0     = r_tag_valid & ~r_tag_port;
  assign rvalid1     = r_tag_valid & r_tag_port;

endmodule

// File: tb/tb_e_mem_arbiter.sv
// Directed vector bench for e_mem_arbiter with MAX_BURST=4 and an E_MEM model holding word[i]=i.
module tb_e_mem_arbiter;
  import e_mem_arbiter_pkg::*;

  localparam int AW = $clog2(MEM_SIZE);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [REG_SIZE-1:0] addr0 = '0, addr1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err;
  logic [REG_SIZE-1:0] mem_address, mem_data, rdata;
  logic [REG_SIZE-1:0] mem [MEM_SIZE];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_address[AW-1:0]];

  e_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .mem_address(mem_address),
    .mem_data(mem_data), .rdata(rdata), .err(err)
  );

  typedef struct {
    logic r0, r1, l0, l1;
    logic [REG_SIZE-1:0] a0, a1;
    logic g0, g1, v0, v1;
    logic [REG_SIZE-1:0] rd, ma;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic l0, input logic l1,
                       input logic [REG_SIZE-1:0] a0, input logic [REG_SIZE-1:0] a1,
                       input logic rs);
    @(negedge clk);
    req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; addr0 = a0; addr1 = a1; rst = rs;
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = REG_SIZE'(i);

    //          r0    r1    l0    l1    a0      a1      g0    g1    v0    v1    rdata   maddr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd5,  16'd20, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd5};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5,  16'd20, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5,  16'd5};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd20};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, 16'd10};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b1, 1'b1, 1'b0, 16'd10, 16'd20};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, 16'd10};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10, 16'd10};
    // locked burst on port 1: four beats, then port 0 wins arbitration
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd20};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 1'b1, 16'd20, 16'd20};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 1'b1, 16'd20, 16'd20};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0, 1'b1, 16'd20, 16'd20};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20, 16'd10};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b1, 1'b0, 16'd10, 16'd20};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b0, 1'b0, 1'b1, 16'd20, 16'd20};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd10, 16'd20, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd10};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10, 16'd10};
    // lock held with no request keeps port 0 out
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd10, 16'd7,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd7};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd7,  1'b0, 1'b0, 1'b0, 1'b1, 16'd7,  16'd7};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd10, 16'd7,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  16'd7};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd7,  1'b0, 1'b1, 1'b0, 1'b1, 16'd7,  16'd7};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd7,  1'b1, 1'b0, 1'b0, 1'b1, 16'd7,  16'd10};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd10, 16'd7,  1'b0, 1'b0, 1'b1, 1'b0, 16'd10, 16'd10};

    // reset state
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2, 1'b1);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_maddr", 32'(mem_address), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].l0, vecs[i].l1, vecs[i].a0, vecs[i].a1, 1'b0);
      check($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
      check($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      check($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
      check($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
      check($sformatf("v%0d_maddr", i), 32'(mem_address), 32'(vecs[i].ma));
      check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      if (vecs[i].v0 || vecs[i].v1)
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd));
    end

    // reset with a read in flight
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd20, 1'b0);
    check("pre_rst_gnt0", 32'(gnt0), 32'd1);
    check("pre_rst_maddr", 32'(mem_address), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd20, 1'b1);
    check("in_rst_gnt0", 32'(gnt0), 32'd0);
    check("in_rst_gnt1", 32'(gnt1), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd20, 1'b0);
    check("post_rst_rvalid0", 32'(rvalid0), 32'd0);
    check("post_rst_rvalid1", 32'(rvalid1), 32'd0);
    check("post_rst_maddr", 32'(mem_address), 32'd0);

    // first contention after reset favours port 0; lock0 then drops after 2 beats
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'd10, 16'd20, 1'b0);
    check("ul_b1_gnt0", 32'(gnt0), 32'd1);
    check("ul_b1_gnt1", 32'(gnt1), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'd10, 16'd20, 1'b0);
    check("ul_b2_gnt0", 32'(gnt0), 32'd1);
    check("ul_b2_rdata", 32'(rdata), 32'd10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0);
    check("ul_drop_gnt0", 32'(gnt0), 32'd1);
    check("ul_drop_gnt1", 32'(gnt1), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 1'b0);
    check("ul_next_gnt0", 32'(gnt0), 32'd0);
    check("ul_next_gnt1", 32'(gnt1), 32'd1);
    check("ul_next_maddr", 32'(mem_address), 32'd20);

    // out-of-range address
    drive(1'b1, 1'b0, 1'b0, 1'b0, REG_SIZE'(MEM_SIZE), 16'd20, 1'b0);
    check("oor_gnt0", 32'(gnt0), 32'd1);
    check("oor_prev_rvalid1", 32'(rvalid1), 32'd1);
    check("oor_prev_rdata", 32'(rdata), 32'd20);
`ifdef E_MEM_BOUNDS_CHECK_EN
    check("oor_maddr", 32'(mem_address), 32'd20);
`else
    check("oor_maddr", 32'(mem_address), 32'(MEM_SIZE));
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    check("oor_rvalid0", 32'(rvalid0), 32'd1);
`ifdef E_MEM_BOUNDS_CHECK_EN
    check("oor_err", 32'(err), 32'd1);
    check("oor_rdata", 32'(rdata), 32'd0);
`else
    check("oor_err", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
